// File: rtl/keypad_scan_ctrl_if.sv
// MCU-facing side of the keypad scanner: latched key code, level interrupt,
// overrun flag and the single-cycle acknowledge.
interface keypad_scan_ctrl_if;
    logic [7:0] DATA;
    logic       INTR;
    logic       INTR_ACK;
    logic       OVERRUN;

    modport slave  (output DATA, output INTR, output OVERRUN, input INTR_ACK);
    modport master (input DATA, input INTR, input OVERRUN, output INTR_ACK);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 matrix keypad scanner: row strobing, press/release debounce, key encoding
// and a level interrupt to the MCU with a sticky overrun flag.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [2:0]               columns,
    output logic [3:0]               rows,
    keypad_scan_ctrl_if.slave        mcu
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} state_e;

    state_e        state_q, state_d;
    logic [2:0]    col_m_q, col_s_q;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    rows_q, rows_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]    cap_col_q, cap_col_d;
    logic [7:0]    data_q, data_d;
    logic          intr_q, intr_d;
    logic          ovr_q, ovr_d;

    logic valid, match, accept, advance, intr_eff;
    logic [1:0] col_idx;
    logic [7:0] code;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_m_q    <= 3'b111;
            col_s_q    <= 3'b111;
            state_q    <= SCAN;
            row_idx_q  <= 2'd0;
            rows_q     <= 4'b1110;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            cap_col_q  <= 3'b111;
            data_q     <= 8'h00;
            intr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            col_m_q    <= columns;
            col_s_q    <= col_m_q;
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            rows_q     <= rows_d;
            scan_cnt_q <= scan_cnt_d;
            db_cnt_q   <= db_cnt_d;
            cap_col_q  <= cap_col_d;
            data_q     <= data_d;
            intr_q     <= intr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Key code from the held row index and the captured single-low column pattern
    always_comb begin
        col_idx = 2'd2;
        if (cap_col_q == 3'b110) col_idx = 2'd0;
        else if (cap_col_q == 3'b101) col_idx = 2'd1;
        if (row_idx_q == 2'd3) begin
            code = (col_idx == 2'd0) ? 8'h0A : (col_idx == 2'd1) ? 8'h00 : 8'h0B;
        end else begin
            code = {6'd0, row_idx_q} * 8'd3 + {6'd0, col_idx} + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        rows_d     = rows_q;
        scan_cnt_d = scan_cnt_q;
        db_cnt_d   = db_cnt_q;
        cap_col_d  = cap_col_q;
        data_d     = data_q;
        accept     = 1'b0;
        advance    = 1'b0;
        valid      = (col_s_q == 3'b110) || (col_s_q == 3'b101) || (col_s_q == 3'b011);
        match      = (col_s_q == cap_col_q);

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (valid) begin
                        cap_col_d = col_s_q;
                        db_cnt_d  = '0;
                        state_d   = PRESS_DB;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            PRESS_DB: begin
                if (!match) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end else if (db_cnt_q == DB_LAST) begin
                    accept   = 1'b1;
                    db_cnt_d = '0;
                    state_d  = HELD;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Any bounce back to a pressed pattern restarts the release count
                if (col_s_q != 3'b111) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = SCAN;
                    advance = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase

        if (advance) begin
            row_idx_d  = row_idx_q + 2'd1;
            rows_d     = ~(4'b0001 << row_idx_d);
            scan_cnt_d = '0;
            db_cnt_d   = '0;
        end

        // Acknowledge clears first so a same-cycle accept lands as a fresh key
        intr_eff = intr_q & ~mcu.INTR_ACK;
        intr_d   = intr_eff;
        ovr_d    = ovr_q & ~mcu.INTR_ACK;
        if (accept) begin
            if (intr_eff) begin
                ovr_d = 1'b1;
            end else begin
                intr_d = 1'b1;
                data_d = code;
            end
        end
    end

    assign rows        = rows_q;
    assign mcu.DATA    = data_q;
    assign mcu.INTR    = intr_q;
    assign mcu.OVERRUN = ovr_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a behavioural 3x4 keypad model.
module tb_keypad_scan_ctrl;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] columns;
    logic [3:0] rows;

    keypad_scan_ctrl_if mcu_if();

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .columns(columns), .rows(rows), .mcu(mcu_if)
    );

    always #5 CLK = ~CLK;

    // keypad model: pressed key pulls its column low while its row is strobed
    logic       key_down, multi;
    logic [1:0] kr, kc;
    always_comb begin
        columns = 3'b111;
        if (multi && !rows[0]) columns = 3'b100;
        if (key_down && !rows[kr]) columns = ~(3'b001 << kc);
    end

    int n_chk = 0, n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        kr = r; kc = c; key_down = 1'b1;
    endtask

    task automatic wait_intr(input string tag, input int budget);
        int n = 0;
        logic [7:0] e;
        while (!mcu_if.INTR && n < budget) begin
            @(negedge CLK); n++;
        end
        chk({tag, "_intr"}, mcu_if.INTR, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        chk({tag, "_data"}, mcu_if.DATA, e);
    endtask

    task automatic wait_rows(input string tag, input logic [3:0] r);
        int n = 0;
        while (rows !== r && n < 64) begin
            @(negedge CLK); n++;
        end
        chk({tag, "_reach"}, rows, r);
    endtask

    task automatic ack;
        mcu_if.INTR_ACK = 1'b1;
        @(negedge CLK);
        mcu_if.INTR_ACK = 1'b0;
    endtask

    logic [3:0] er;
    logic seen;
    int n;

    initial begin
        RST_N = 1'b0; mcu_if.INTR_ACK = 1'b0; key_down = 1'b0; multi = 1'b0; kr = 0; kc = 0;
        repeat (3) @(negedge CLK);
        chk("rst_rows", rows, 4'b1110);
        chk("rst_data", mcu_if.DATA, 0);
        chk("rst_intr", mcu_if.INTR, 0);
        chk("rst_ovr", mcu_if.OVERRUN, 0);

        // 1: idle scan
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            er = ~(4'b0001 << ((i / 4) % 4));
            chk("s1_rows", rows, er);
            @(negedge CLK);
        end
        chk("s1_intr", mcu_if.INTR, 0);

        // 2: key 5 held
        press(2'd1, 2'd1); exp_q.push_back(8'h05);
        wait_intr("s2", 27);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); chk("s2_frozen", rows, 4'b1101);
        end
        key_down = 1'b0;
        repeat (9) @(negedge CLK);
        chk("s2_still_held", rows, 4'b1101);
        @(negedge CLK);
        chk("s2_resume", rows, 4'b1011);
        ack;
        chk("s2_ack", mcu_if.INTR, 0);

        // 3: bouncing '#'
        kr = 2'd3; kc = 2'd2; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            key_down = ~key_down;
            repeat (3) begin @(negedge CLK); seen |= mcu_if.INTR; end
        end
        chk("s3_bounce_intr", seen, 0);
        press(2'd3, 2'd2); exp_q.push_back(8'h0B);
        wait_intr("s3", 40);
        repeat (30) @(negedge CLK);
        chk("s3_single", mcu_if.OVERRUN, 0);
        key_down = 1'b0;
        repeat (20) @(negedge CLK);
        ack;

        // 4: overrun
        press(2'd0, 2'd0); exp_q.push_back(8'h01);
        wait_intr("s4", 40);
        key_down = 1'b0;
        repeat (20) @(negedge CLK);
        press(2'd3, 2'd1);
        n = 0;
        while (!mcu_if.OVERRUN && n < 40) begin @(negedge CLK); n++; end
        chk("s4_ovr", mcu_if.OVERRUN, 1);
        chk("s4_data", mcu_if.DATA, 8'h01);
        chk("s4_intr", mcu_if.INTR, 1);
        key_down = 1'b0;
        repeat (20) @(negedge CLK);
        ack;
        chk("s4_ack_intr", mcu_if.INTR, 0);
        chk("s4_ack_ovr", mcu_if.OVERRUN, 0);

        // 5: ack on the accept cycle of '9'
        press(2'd0, 2'd2); exp_q.push_back(8'h03);
        wait_intr("s5a", 40);
        key_down = 1'b0;
        repeat (20) @(negedge CLK);
        wait_rows("s5_row1", 4'b1101);
        press(2'd2, 2'd2); exp_q.push_back(8'h09);
        wait_rows("s5_row2", 4'b1011);
        repeat (11) @(negedge CLK);
        ack;
        wait_intr("s5b", 0);
        chk("s5_ovr", mcu_if.OVERRUN, 0);
        key_down = 1'b0;
        repeat (20) @(negedge CLK);
        chk("s5_single", mcu_if.OVERRUN, 0);

        // 6: two columns low is no key, then reset mid-debounce
        multi = 1'b1; seen = 1'b0;
        for (int i = 0; i < 24; i++) begin @(negedge CLK); seen |= (rows == 4'b1011); end
        chk("s6_multi_scan", seen, 1);
        chk("s6_multi_ovr", mcu_if.OVERRUN, 0);
        chk("s6_multi_data", mcu_if.DATA, 8'h09);
        multi = 1'b0;
        wait_rows("s6_row3", 4'b0111);
        press(2'd0, 2'd1);
        wait_rows("s6_row0", 4'b1110);
        repeat (7) @(negedge CLK);
        chk("s6_pre_ovr", mcu_if.OVERRUN, 0);
        chk("s6_pre_intr", mcu_if.INTR, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("s6_rst_rows", rows, 4'b1110);
        chk("s6_rst_data", mcu_if.DATA, 0);
        chk("s6_rst_intr", mcu_if.INTR, 0);
        chk("s6_rst_ovr", mcu_if.OVERRUN, 0);
        @(negedge CLK);
        RST_N = 1'b1; exp_q.push_back(8'h02);
        wait_intr("s6", 27);
        key_down = 1'b0;
        repeat (5) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
